// File: rtl/axi_mem_pkg.sv
// Shared types and address arithmetic for the AXI4 burst memory slave.
// Used by axi4_burst_mem_slave and axi_mem_addr_gen.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  // Wide intermediate so callers of any address width can truncate the result.
  function automatic logic [63:0] calc_next_addr(input logic [63:0] addr,
                                                 input logic [7:0]  len,
                                                 input logic [2:0]  size,
                                                 input burst_e      burst);
    logic [63:0] incr;
    logic [63:0] wrap_mask;
    incr      = 64'd1 << size;
    wrap_mask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_INCR: calc_next_addr = addr + incr;
      BURST_WRAP: calc_next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
      default:    calc_next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) between a master and axi4_burst_mem_slave.
interface axi4_burst_mem_slave_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned IdWidth   = 1
);

  logic [IdWidth-1:0]     awid;
  logic [AddrWidth-1:0]   awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;

  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [IdWidth-1:0]     bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  logic [IdWidth-1:0]     arid;
  logic [AddrWidth-1:0]   araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;

  logic [IdWidth-1:0]     rid;
  logic [DataWidth-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_mem_addr_gen.sv
// Per-beat address decode: word index, next beat address and error flag.
// Config macro: AXI_MEM_WRAP_EN enables WRAP bursts; otherwise WRAP is always an error.
module axi_mem_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MemDepth  = 256
) (
  input  logic [AddrWidth-1:0]         addr_i,
  input  logic [7:0]                   len_i,
  input  logic [2:0]                   size_i,
  input  logic [1:0]                   burst_i,
  output logic [AddrWidth-1:0]         next_addr_o,
  output logic [$clog2(MemDepth)-1:0]  word_o,
  output logic                         err_o
);

  localparam int unsigned LaneBits = $clog2(DataWidth / 8);
  localparam int unsigned WordBits = $clog2(MemDepth);

`ifdef AXI_MEM_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  burst_e               burst;
  logic [AddrWidth-1:0] word_idx;
  logic                 wrap_len_ok;
  logic                 burst_err;
  logic                 range_err;

  assign burst       = burst_e'(burst_i);
  assign wrap_len_ok = len_i inside {8'd1, 8'd3, 8'd7, 8'd15};

  // Burst-level errors hold for every beat, so the whole burst skips memory.
  assign burst_err = (burst == BURST_RSVD) | (size_i > 3'(LaneBits)) |
                     ((burst == BURST_WRAP) & (~WrapEn | ~wrap_len_ok));

  assign word_idx  = addr_i >> LaneBits;
  assign range_err = word_idx >= AddrWidth'(MemDepth);

  assign err_o       = burst_err | range_err;
  assign word_o      = word_idx[WordBits-1:0];
  assign next_addr_o = AddrWidth'(calc_next_addr(64'(addr_i), len_i, size_i, burst));

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst slave over an internal byte-writable RAM with independent write/read FSMs.
// Config macro: AXI_MEM_WRAP_EN (see axi_mem_addr_gen).
module axi4_burst_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned MEM_DEPTH_WORDS    = 256
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  axi4_burst_mem_slave_if.slave   s_axi
);

  localparam int unsigned Lanes    = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned WordBits = $clog2(MEM_DEPTH_WORDS);

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  // Holds all ready outputs low during reset and until the first clock after release.
  logic ready_en_q;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) ready_en_q <= 1'b0;
    else                  ready_en_q <= 1'b1;
  end

  // Write channel
  wstate_e                       wstate_q, wstate_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_addr_q, w_next;
  logic [7:0]                    w_len_q, w_cnt_q;
  logic [2:0]                    w_size_q;
  logic [1:0]                    w_burst_q;
  logic                          w_err_q, w_err;
  logic [C_S_AXI_ID_WIDTH-1:0]   bid_q;
  resp_e                         bresp_q;
  logic [WordBits-1:0]           w_word;
  logic                          aw_hs, w_hs, b_hs, w_last_beat;

  assign s_axi.awready = ready_en_q & (wstate_q == W_IDLE);
  assign s_axi.wready  = ready_en_q & (wstate_q == W_DATA);
  assign s_axi.bvalid  = (wstate_q == W_RESP);
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;

  assign aw_hs       = s_axi.awvalid & s_axi.awready;
  assign w_hs        = s_axi.wvalid & s_axi.wready;
  assign b_hs        = s_axi.bvalid & s_axi.bready;
  assign w_last_beat = (w_cnt_q == w_len_q);

  axi_mem_addr_gen #(
    .AddrWidth (C_S_AXI_ADDR_WIDTH),
    .DataWidth (C_S_AXI_DATA_WIDTH),
    .MemDepth  (MEM_DEPTH_WORDS)
  ) u_w_addr_gen (
    .addr_i      (w_addr_q),
    .len_i       (w_len_q),
    .size_i      (w_size_q),
    .burst_i     (w_burst_q),
    .next_addr_o (w_next),
    .word_o      (w_word),
    .err_o       (w_err)
  );

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (aw_hs) wstate_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) wstate_d = W_RESP;
      W_RESP:  if (b_hs) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wstate_q  <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      if (aw_hs) begin
        w_addr_q  <= s_axi.awaddr;
        w_len_q   <= s_axi.awlen;
        w_size_q  <= s_axi.awsize;
        w_burst_q <= s_axi.awburst;
        w_cnt_q   <= '0;
        w_err_q   <= 1'b0;
        bid_q     <= s_axi.awid;
      end else if (w_hs) begin
        w_addr_q <= w_next;
        w_cnt_q  <= w_cnt_q + 8'd1;
        w_err_q  <= w_err_q | w_err;
        if (w_last_beat) bresp_q <= (w_err_q | w_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // RAM has no reset; contents survive s00_axi_aresetn.
  always_ff @(posedge s00_axi_aclk) begin
    if (w_hs && !w_err) begin
      for (int b = 0; b < Lanes; b++) begin
        if (s_axi.wstrb[b]) mem[w_word][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  // Read channel
  rstate_e                       rstate_q, rstate_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_addr_q, r_next;
  logic [7:0]                    r_len_q;
  logic [8:0]                    r_cnt_q;
  logic [2:0]                    r_size_q;
  logic [1:0]                    r_burst_q;
  logic                          r_prime_q, r_err;
  logic [WordBits-1:0]           r_word;
  logic [C_S_AXI_ID_WIDTH-1:0]   rid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  resp_e                         rresp_q;
  logic                          rlast_q, rvalid_q;
  logic                          ar_hs, r_hs, r_issue;

  assign s_axi.arready = ready_en_q & (rstate_q == R_IDLE);
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;

  assign ar_hs = s_axi.arvalid & s_axi.arready;
  assign r_hs  = rvalid_q & s_axi.rready;

  // r_prime_q skips the first cycle in R_DATA so the first beat lands two cycles after AR.
  assign r_issue = (rstate_q == R_DATA) & ~r_prime_q & (r_cnt_q <= {1'b0, r_len_q}) &
                   (~rvalid_q | s_axi.rready);

  axi_mem_addr_gen #(
    .AddrWidth (C_S_AXI_ADDR_WIDTH),
    .DataWidth (C_S_AXI_DATA_WIDTH),
    .MemDepth  (MEM_DEPTH_WORDS)
  ) u_r_addr_gen (
    .addr_i      (r_addr_q),
    .len_i       (r_len_q),
    .size_i      (r_size_q),
    .burst_i     (r_burst_q),
    .next_addr_o (r_next),
    .word_o      (r_word),
    .err_o       (r_err)
  );

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rstate_q  <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_prime_q <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      r_prime_q <= ar_hs;
      if (ar_hs) begin
        r_addr_q  <= s_axi.araddr;
        r_len_q   <= s_axi.arlen;
        r_size_q  <= s_axi.arsize;
        r_burst_q <= s_axi.arburst;
        r_cnt_q   <= '0;
        rid_q     <= s_axi.arid;
      end
      if (r_issue) begin
        rvalid_q <= 1'b1;
        rdata_q  <= r_err ? '0 : mem[r_word];
        rresp_q  <= r_err ? RESP_SLVERR : RESP_OKAY;
        rlast_q  <= (r_cnt_q[7:0] == r_len_q);
        r_addr_q <= r_next;
        r_cnt_q  <= r_cnt_q + 9'd1;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axi4_burst_mem_slave.md
AXI4_BURST_MEM_SLAVE -- requirements
Module: axi4_burst_mem_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; legal values 32, 64, 128.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 12, byte address width.
REQ-003 SHALL have parameter C_S_AXI_ID_WIDTH, default 1, AXI ID width.
REQ-004 SHALL have parameter MEM_DEPTH_WORDS, default 256, internal RAM depth in bus-width words, power of two.
REQ-005 SHALL have s00_axi_aclk, input, 1 bit: the single clock; all logic rising-edge.
REQ-006 SHALL have s00_axi_aresetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have the AW channel as inputs awid(ID), awaddr(ADDR), awlen(8), awsize(3), awburst(2), awvalid(1), plus output awready(1).
REQ-008 SHALL have the W channel as inputs wdata(DATA), wstrb(DATA/8), wlast(1), wvalid(1), plus output wready(1).
REQ-009 SHALL have the B channel as outputs bid(ID), bresp(2), bvalid(1), plus input bready(1).
REQ-010 SHALL have the AR channel as inputs arid, araddr, arlen, arsize, arburst, arvalid (widths as AW), plus output arready(1).
REQ-011 SHALL have the R channel as outputs rid(ID), rdata(DATA), rresp(2), rlast(1), rvalid(1), plus input rready(1).

Function
REQ-012 Write FSM SHALL use states W_IDLE -> W_DATA (on AW handshake) -> W_RESP (on W handshake with beat count = awlen) -> W_IDLE (on B handshake).
REQ-013 Read FSM SHALL use states R_IDLE -> R_DATA (on AR handshake) -> R_IDLE (on R handshake of beat arlen); it runs concurrently with and independently of the write FSM.
REQ-014 awready/arready SHALL be high only in W_IDLE/R_IDLE; wready SHALL be high only in W_DATA.
REQ-015 Each accepted W beat SHALL write the bytes enabled by wstrb in the same cycle; disabled bytes SHALL be unchanged.
REQ-016 First rvalid SHALL assert 2 cycles after the AR handshake; with rready held high, beats SHALL stream one per cycle; rdata/rresp/rlast SHALL stay stable while rvalid=1 and rready=0.
REQ-017 Next address: FIXED = unchanged; INCR = addr + 2^size; WRAP = increments within the block aligned to (len+1)*2^size.
REQ-018 WRAP with len not in {1,3,7,15}, size > log2(DATA/8), or burst=2'b11 SHALL complete all beats without memory access and return SLVERR (2'b10).
REQ-019 Beats with word index >= MEM_DEPTH_WORDS SHALL not be written; such reads return rdata=0; in both cases the response is SLVERR.
REQ-020 bresp SHALL be SLVERR if any beat of the burst erred, else OKAY; rresp SHALL be per beat.
REQ-021 bid/rid SHALL echo awid/arid; rlast SHALL be high only on beat arlen.
REQ-022 A read and a write to the same word in the same cycle SHALL return the old data.
REQ-023 wlast mismatching the beat count SHALL be ignored; the beat count is authoritative.

Reset
REQ-024 On s00_axi_aresetn low, all ready/valid outputs, bid, rid, bresp, rresp, rdata, and rlast SHALL be 0, and both FSMs SHALL return to IDLE, including mid-burst.
REQ-025 RAM contents SHALL NOT be cleared by reset; ready outputs SHALL rise the first cycle after reset release.

Configuration
REQ-026 Macro AXI_MEM_WRAP_EN: when defined, WRAP bursts behave per REQ-017; when undefined, every WRAP burst is treated as an error per REQ-018 (SLVERR, no memory access).

Structure
REQ-027 Package axi_mem_pkg SHALL hold burst-type and response enums, write/read FSM state enums, and the next-address function.
REQ-028 Sub-module axi_mem_addr_gen SHALL compute the per-beat address and error flag, and SHALL be instantiated once per channel.

Verification
REQ-029 INCR len=7 size=2 addr 0x0, write data 1..8, then read back -> rdata 1..8, all responses OKAY, rlast on beat 8.
REQ-030 WRAP len=3 size=2 addr 0x18 -> beats at 0x18, 0x1C, 0x10, 0x14; without AXI_MEM_WRAP_EN -> bresp SLVERR and memory unchanged.
REQ-031 Word 0x11223344 at 0x40, then write 0xAABBCCDD with wstrb 4'b0011 -> read 0x1122CCDD.
REQ-032 Write len=1 starting at the last valid word -> beat 0 stored, beat 1 dropped, bresp SLVERR; read of the same range -> rresp OKAY then SLVERR with rdata 0.
REQ-033 Read len=7 with rready toggled 1,0,0,1,... -> no lost or duplicated beats, and data held stable while stalled.
REQ-034 Reset asserted after write beat 3 of 8 -> all valids 0 immediately, awready 1 the cycle after release, beats 0..2 retained in RAM.
